mem_init_ctrl: RTL and testbench

//  Parametrised memory initialiser. Sweeps a single-port RAM write port over

---
 rtl/mem_init_pkg.sv | 10 +
 rtl/mem_init_datagen.sv | 30 +++
 rtl/mem_init_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_init_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_init_pkg.sv
// Shared types for the memory initialiser: pattern modes and sweep states.
package mem_init_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {ZERO, RAMP, CONST, XOR} init_mode_e;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} init_state_e;

endpackage

// File: rtl/mem_init_datagen.sv
// Combinational pattern generator: maps (mode, address, fill) to a RAM data word.
module mem_init_datagen
  import mem_init_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  init_mode_e        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] fill,
  output logic [DATA_W-1:0] data_c
);

  // Address adapted to the data width: LSBs kept when wider, zero-extended when narrower.
  logic [DATA_W-1:0] addr_w;
  assign addr_w = DATA_W'(addr);

  // Pattern select.
  always_comb begin
    data_c = '0;
    case (mode)
      ZERO:    data_c = '0;
      RAMP:    data_c = addr_w;
      CONST:   data_c = fill;
      XOR:     data_c = addr_w ^ fill;
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_init_ctrl.sv
// Memory initialiser: sweeps a RAM write port over 0..DEPTH-1 writing a selected pattern.
module mem_init_ctrl
  import mem_init_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  init_state_e       state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  init_mode_e        mode_q, mode_nxt;
  logic [DATA_W-1:0] fill_q, fill_nxt;
  logic              busy_nxt, done_nxt, rdy_nxt, wren_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wrdata_nxt;
  logic [DATA_W-1:0] gen_data_c;

  mem_init_datagen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_datagen (
    .mode   (mode_q),
    .addr   (cnt),
    .fill   (fill_q),
    .data_c (gen_data_c)
  );

  // State, sweep counter, latched operands and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mode_q <= ZERO;
      fill_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdy    <= 1'b0;
      addr   <= '0;
      wrdata <= '0;
      wren   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      fill_q <= fill_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      rdy    <= rdy_nxt;
      addr   <= addr_nxt;
      wrdata <= wrdata_nxt;
      wren   <= wren_nxt;
    end
  end

  // Next state and next output values; the registered wren marks the first DONE cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mode_nxt   = mode_q;
    fill_nxt   = fill_q;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    rdy_nxt    = rdy;
    addr_nxt   = '0;
    wrdata_nxt = '0;
    wren_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (abort) begin
          rdy_nxt = 1'b0;
        end else if (start) begin
          state_nxt = S_WRITE;
          cnt_nxt   = '0;
          mode_nxt  = init_mode_e'(mode);
          fill_nxt  = fill;
          rdy_nxt   = 1'b0;
        end
      end

      S_WRITE: begin
        if (abort) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          rdy_nxt   = 1'b0;
        end else begin
          wren_nxt   = 1'b1;
          busy_nxt   = 1'b1;
          addr_nxt   = cnt;
          wrdata_nxt = gen_data_c;
          if (cnt == LAST_ADDR) begin
            state_nxt = S_DONE;
          end else begin
            cnt_nxt = cnt + ADDR_W'(1);
          end
        end
      end

      S_DONE: begin
        if (abort) begin
          state_nxt = S_IDLE;
          rdy_nxt   = 1'b0;
        end else begin
          done_nxt = wren;
          if (start) begin
            state_nxt = S_WRITE;
            cnt_nxt   = '0;
            mode_nxt  = init_mode_e'(mode);
            fill_nxt  = fill;
            rdy_nxt   = 1'b0;
          end else begin
            rdy_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_init_ctrl.sv
// Randomised and directed bench for mem_init_ctrl: two instances (full-depth 8-bit, and
// 10-bit address with partial depth) checked against a sweep-position reference model.
module tb_mem_init_ctrl;

  localparam int unsigned DW      = 8;
  localparam int unsigned AW_A    = 8;
  localparam int unsigned DEPTH_A = 256;
  localparam int unsigned AW_B    = 10;
  localparam int unsigned DEPTH_B = 700;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [1:0]      mode;
  logic [DW-1:0]   fill;

  logic            a_busy, a_done, a_rdy, a_wren;
  logic [AW_A-1:0] a_addr;
  logic [DW-1:0]   a_wrdata;
  logic            b_busy, b_done, b_rdy, b_wren;
  logic [AW_B-1:0] b_addr;
  logic [DW-1:0]   b_wrdata;

  mem_init_ctrl #(.ADDR_W(AW_A), .DATA_W(DW), .DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .fill(fill), .abort(abort),
    .busy(a_busy), .done(a_done), .rdy(a_rdy), .addr(a_addr), .wrdata(a_wrdata), .wren(a_wren)
  );

  mem_init_ctrl #(.ADDR_W(AW_B), .DATA_W(DW), .DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .fill(fill), .abort(abort),
    .busy(b_busy), .done(b_done), .rdy(b_rdy), .addr(b_addr), .wrdata(b_wrdata), .wren(b_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Single comparison point: counts every check, reports each mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: each sweep is described by its position j (edges since acceptance).
  int unsigned m_depth [2];
  bit          m_active[2];
  int          m_j     [2];
  bit          m_pend  [2];
  bit          m_rdy   [2];
  logic [1:0]  m_mode  [2];
  logic [7:0]  m_fill  [2];
  bit          e_wren  [2];
  bit          e_done  [2];
  bit          e_rdy   [2];
  int          e_addr  [2];
  logic [7:0]  e_data  [2];
  bit          e_rst;

  function automatic logic [7:0] pat(input logic [1:0] md, input int a, input logic [7:0] f);
    logic [7:0] a8;
    a8 = a[7:0];
    case (md)
      2'd0:    return 8'h00;
      2'd1:    return a8;
      2'd2:    return f;
      default: return a8 ^ f;
    endcase
  endfunction

  task automatic model_edge();
    e_rst = !rst_n;
    for (int d = 0; d < 2; d++) begin
      e_wren[d] = 1'b0;
      e_done[d] = 1'b0;
      e_addr[d] = 0;
      e_data[d] = 8'h00;
      if (!rst_n) begin
        m_active[d] = 1'b0;
        m_pend[d]   = 1'b0;
        m_rdy[d]    = 1'b0;
      end else if (m_active[d]) begin
        if (abort) begin
          m_active[d] = 1'b0;
          m_rdy[d]    = 1'b0;
        end else begin
          e_wren[d] = 1'b1;
          e_addr[d] = m_j[d] - 1;
          e_data[d] = pat(m_mode[d], m_j[d] - 1, m_fill[d]);
          if (m_j[d] == int'(m_depth[d])) begin
            m_active[d] = 1'b0;
            m_pend[d]   = 1'b1;
          end
          m_j[d]++;
        end
      end else begin
        if (abort) begin
          m_rdy[d]  = 1'b0;
          m_pend[d] = 1'b0;
        end else begin
          e_done[d] = m_pend[d];
          if (start) begin
            m_active[d] = 1'b1;
            m_j[d]      = 1;
            m_mode[d]   = mode;
            m_fill[d]   = fill;
            m_rdy[d]    = 1'b0;
          end else if (m_pend[d]) begin
            m_rdy[d] = 1'b1;
          end
          m_pend[d] = 1'b0;
        end
      end
      e_rdy[d] = m_rdy[d];
    end
  endtask

  int  wr_a, wr_b, done_a, done_b;
  bit  chk_ramp, chk_xor;

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("a_wren", 32'(a_wren), 32'(e_wren[0]));
    check("a_busy", 32'(a_busy), 32'(e_wren[0]));
    check("a_done", 32'(a_done), 32'(e_done[0]));
    check("a_rdy",  32'(a_rdy),  32'(e_rdy[0]));
    check("a_addr", 32'(a_addr), 32'(e_addr[0]));
    if (e_wren[0] || e_rst) check("a_wrdata", 32'(a_wrdata), 32'(e_data[0]));
    check("b_wren", 32'(b_wren), 32'(e_wren[1]));
    check("b_busy", 32'(b_busy), 32'(e_wren[1]));
    check("b_done", 32'(b_done), 32'(e_done[1]));
    check("b_rdy",  32'(b_rdy),  32'(e_rdy[1]));
    check("b_addr", 32'(b_addr), 32'(e_addr[1]));
    if (e_wren[1] || e_rst) check("b_wrdata", 32'(b_wrdata), 32'(e_data[1]));
    if (b_wren) check("b_addr_in_range", 32'(b_addr < AW_B'(DEPTH_B)), 32'd1);
    if (chk_ramp && b_wren && b_addr == 10'h2A3) check("ramp_trunc_b", 32'(b_wrdata), 32'hA3);
    if (chk_xor && a_wren && a_addr == 8'h10) check("xor_a_0x10", 32'(a_wrdata), 32'hEF);
    if (a_wren) wr_a++;
    if (b_wren) wr_b++;
    if (a_done) done_a++;
    if (b_done) done_b++;
  endtask

  task automatic clr_cnt();
    wr_a = 0; wr_b = 0; done_a = 0; done_b = 0;
  endtask

  task automatic pulse_start(input logic [1:0] md, input logic [7:0] f);
    mode  = md;
    fill  = f;
    start = 1'b1;
    step();
    start = 1'b0;
    mode  = 2'($urandom);
    fill  = 8'($urandom);
    clr_cnt();
  endtask

  initial begin
    m_depth[0] = DEPTH_A;
    m_depth[1] = DEPTH_B;
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0; m_j[d] = 0; m_pend[d] = 1'b0; m_rdy[d] = 1'b0;
      m_mode[d] = 2'd0; m_fill[d] = 8'h00;
    end
    chk_ramp = 1'b0; chk_xor = 1'b0;
    clr_cnt();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; fill = 8'h00;

    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Ramp sweep on both instances.
    chk_ramp = 1'b1;
    pulse_start(2'd1, 8'h00);
    repeat (DEPTH_B + 5) step();
    chk_ramp = 1'b0;
    check("ramp_writes_a", 32'(wr_a), 32'd256);
    check("ramp_done_a", 32'(done_a), 32'd1);
    check("ramp_writes_b", 32'(wr_b), 32'd700);
    check("ramp_done_b", 32'(done_b), 32'd1);
    check("ramp_rdy_a", 32'(a_rdy), 32'd1);

    // Constant and xor fills.
    pulse_start(2'd2, 8'hA5);
    repeat (DEPTH_B + 5) step();
    chk_xor = 1'b1;
    pulse_start(2'd3, 8'hFF);
    repeat (DEPTH_B + 5) step();
    chk_xor = 1'b0;

    // Abort at write 100, then a clean sweep.
    pulse_start(2'd1, 8'h00);
    repeat (100) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_wren_a", 32'(a_wren), 32'd0);
    check("abort_rdy_a", 32'(a_rdy), 32'd0);
    clr_cnt();
    repeat (DEPTH_B + 5) step();
    check("abort_no_done_a", 32'(done_a), 32'd0);
    check("abort_no_writes_b", 32'(wr_b), 32'd0);
    pulse_start(2'd0, 8'h00);
    repeat (DEPTH_B + 5) step();
    check("post_abort_writes_a", 32'(wr_a), 32'd256);
    check("post_abort_done_b", 32'(done_b), 32'd1);

    // Start held with a different mode during a sweep, then reset mid-sweep.
    pulse_start(2'd1, 8'h00);
    start = 1'b1;
    mode  = 2'd2;
    fill  = 8'h3C;
    repeat (49) step();
    start = 1'b0;
    rst_n = 1'b0;
    step();
    check("rst_mid_wren_a", 32'(a_wren), 32'd0);
    check("rst_mid_addr_b", 32'(b_addr), 32'd0);
    step();
    rst_n = 1'b1;
    clr_cnt();
    repeat (20) step();
    check("rst_mid_no_writes_a", 32'(wr_a), 32'd0);

    // Start tied high: back-to-back sweeps separated by one done cycle.
    mode  = 2'd3;
    fill  = 8'h5A;
    start = 1'b1;
    step();
    clr_cnt();
    repeat (1499) step();
    start = 1'b0;
    check("b2b_done_a", 32'(done_a), 32'd5);
    check("b2b_writes_a", 32'(wr_a), 32'd1494);
    check("b2b_done_b", 32'(done_b), 32'd2);
    check("b2b_writes_b", 32'(wr_b), 32'd1497);
    repeat (DEPTH_B + 5) step();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 399) == 0);
      rst_n = !($urandom_range(0, 999) == 0);
      mode  = 2'($urandom);
      fill  = 8'($urandom);
      step();
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
